// File: rtl/aexm_dcache.sv
// rtl/aexm_dcache.sv - direct-mapped write-through no-write-allocate L1 data cache (optional stats: AEXM_DCACHE_STATS_EN)
module aexm_dcache #(
    parameter int SETS_LOG2 = 6,
    parameter int LW_LOG2   = 2
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic [31:0] aexm_dcache_precycle_addr,
    input  logic        aexm_dcache_precycle_enable,
    input  logic        aexm_dcache_precycle_we,
    input  logic        aexm_dcache_force_miss,
    input  logic [31:0] aexm_dcache_datao,
    output logic [31:0] aexm_dcache_datai,
    output logic        aexm_dcache_cache_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef AEXM_DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int SETS    = 1 << SETS_LOG2;
    localparam int WORDS   = 1 << LW_LOG2;
    localparam int TAG_LSB = SETS_LOG2 + LW_LOG2 + 2;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ACCESS, S_FILL, S_REPLAY, S_WRITE, S_UNC} state_t;

    state_t state, next_state;

    logic [TAG_W-1:0]     tag_ram   [SETS];
    logic                 valid_ram [SETS];
    logic [31:0]          data_ram  [SETS*WORDS];

    logic [SETS_LOG2-1:0] init_cnt;
    logic [LW_LOG2-1:0]   wcnt;
    logic [LW_LOG2-1:0]   wnext;
    logic [31:2]          a_addr;
    logic                 a_we;
    logic                 a_force;
    logic                 done;
    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_valid;

    logic [SETS_LOG2-1:0] a_idx, p_idx;
    logic [LW_LOG2-1:0]   a_word, p_word;
    logic [TAG_W-1:0]     a_tag;
    logic                 hit, ack, sample;
    logic                 unused_bits;

    assign a_idx  = a_addr[TAG_LSB-1:LW_LOG2+2];
    assign a_word = a_addr[LW_LOG2+1:2];
    assign a_tag  = a_addr[31:TAG_LSB];
    assign p_idx  = aexm_dcache_precycle_addr[TAG_LSB-1:LW_LOG2+2];
    assign p_word = aexm_dcache_precycle_addr[LW_LOG2+1:2];
    assign unused_bits = ^aexm_dcache_precycle_addr[1:0];

    // forced accesses never hit so the line is left alone even when the tag matches
    assign hit    = rd_valid && (rd_tag == a_tag) && !a_force;
    // acks outside a request are ignored
    assign ack    = mem_ack && mem_req;
    assign sample = !aexm_dcache_cache_busy && (state == S_IDLE || state == S_ACCESS);
    assign wnext  = wcnt + 1'b1;

    // state register
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) state <= S_INIT;
        else       state <= next_state;
    end

    // next-state and combinational stall
    always_comb begin
        next_state             = state;
        aexm_dcache_cache_busy = 1'b1;
        case (state)
            S_INIT:   if (&init_cnt) next_state = S_IDLE;
            S_IDLE: begin
                aexm_dcache_cache_busy = 1'b0;
                next_state = aexm_dcache_precycle_enable ? S_ACCESS : S_IDLE;
            end
            S_ACCESS: begin
                if (done || (!a_we && hit)) begin
                    aexm_dcache_cache_busy = 1'b0;
                    next_state = aexm_dcache_precycle_enable ? S_ACCESS : S_IDLE;
                end else if (a_we) begin
                    next_state = S_WRITE;
                end else if (a_force) begin
                    next_state = S_UNC;
                end else begin
                    next_state = S_FILL;
                end
            end
            S_FILL:   if (ack && &wcnt) next_state = S_REPLAY;
            S_REPLAY: next_state = S_ACCESS;
            S_UNC:    if (ack) next_state = S_ACCESS;
            S_WRITE:  if (ack) next_state = S_IDLE;
            default:  next_state = S_INIT;
        endcase
    end

    // access latch, registered RAM read port and memory-port drivers
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            init_cnt          <= '0;
            wcnt              <= '0;
            a_addr            <= '0;
            a_we              <= 1'b0;
            a_force           <= 1'b0;
            done              <= 1'b0;
            rd_tag            <= '0;
            rd_valid          <= 1'b0;
            aexm_dcache_datai <= '0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
        end else begin
            done <= (state == S_UNC) && ack;
            if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
            if (sample && aexm_dcache_precycle_enable) begin
                a_addr            <= aexm_dcache_precycle_addr[31:2];
                a_we              <= aexm_dcache_precycle_we;
                a_force           <= aexm_dcache_force_miss;
                aexm_dcache_datai <= data_ram[{p_idx, p_word}];
                rd_tag            <= tag_ram[p_idx];
                rd_valid          <= valid_ram[p_idx];
            end
            case (state)
                S_ACCESS: begin
                    if (next_state == S_WRITE) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {a_addr, 2'b00};
                        mem_wdata <= aexm_dcache_datao;
                    end else if (next_state == S_FILL) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        wcnt     <= '0;
                        mem_addr <= {a_addr[31:LW_LOG2+2], {LW_LOG2{1'b0}}, 2'b00};
                    end else if (next_state == S_UNC) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {a_addr, 2'b00};
                    end
                end
                S_FILL: if (ack) begin
                    wcnt     <= wnext;
                    mem_addr <= {a_addr[31:LW_LOG2+2], wnext, 2'b00};
                    if (&wcnt) mem_req <= 1'b0;
                end
                S_REPLAY: begin
                    aexm_dcache_datai <= data_ram[{a_idx, a_word}];
                    rd_tag            <= tag_ram[a_idx];
                    rd_valid          <= valid_ram[a_idx];
                end
                S_UNC: if (ack) begin
                    aexm_dcache_datai <= mem_rdata;
                    mem_req           <= 1'b0;
                end
                S_WRITE: if (ack) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // tag/valid/data RAM writes: invalidate sweep, store-hit update, line refill
    always_ff @(posedge gclk) begin
        if (state == S_INIT) valid_ram[init_cnt] <= 1'b0;
        if (state == S_ACCESS && a_we && hit) data_ram[{a_idx, a_word}] <= aexm_dcache_datao;
        if (state == S_FILL && ack) begin
            data_ram[{a_idx, wcnt}] <= mem_rdata;
            if (&wcnt) begin
                tag_ram[a_idx]   <= a_tag;
                valid_ram[a_idx] <= 1'b1;
            end
        end
    end

`ifdef AEXM_DCACHE_STATS_EN
    // saturating hit/miss counters for plain loads
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (state == S_ACCESS && !a_we && hit && stat_hits != 32'hFFFF_FFFF)
                stat_hits <= stat_hits + 1'b1;
            if (state == S_ACCESS && next_state == S_FILL && stat_misses != 32'hFFFF_FFFF)
                stat_misses <= stat_misses + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aexm_dcache.sv
// tb/tb_aexm_dcache.sv - directed self-checking bench for aexm_dcache
module tb_aexm_dcache;
    logic        gclk;
    logic        grst;
    logic [31:0] p_addr;
    logic        p_en;
    logic        p_we;
    logic        p_force;
    logic [31:0] datao;
    logic [31:0] datai;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef AEXM_DCACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] rd_log [$];
    logic [31:0] wr_log_addr [$];
    logic [31:0] wr_log_data [$];

    aexm_dcache dut (
        .gclk                        (gclk),
        .grst                        (grst),
        .aexm_dcache_precycle_addr   (p_addr),
        .aexm_dcache_precycle_enable (p_en),
        .aexm_dcache_precycle_we     (p_we),
        .aexm_dcache_force_miss      (p_force),
        .aexm_dcache_datao           (datao),
        .aexm_dcache_datai           (datai),
        .aexm_dcache_cache_busy      (busy),
        .mem_req                     (mem_req),
        .mem_we                      (mem_we),
        .mem_addr                    (mem_addr),
        .mem_wdata                   (mem_wdata),
        .mem_rdata                   (mem_rdata),
        .mem_ack                     (mem_ack)
`ifdef AEXM_DCACHE_STATS_EN
        ,
        .stat_hits                   (stat_hits),
        .stat_misses                 (stat_misses)
`endif
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a;
    endfunction

    // memory responder: acks every requested word one half-cycle after it appears
    always @(negedge gclk) begin
        if (mem_req) begin
            mem_ack = 1'b1;
            if (mem_we) begin
                mem_model[mem_addr] = mem_wdata;
                wr_log_addr.push_back(mem_addr);
                wr_log_data.push_back(mem_wdata);
            end else begin
                mem_rdata = mem_rd(mem_addr);
                rd_log.push_back(mem_addr);
            end
        end else begin
            mem_ack = 1'b0;
        end
    end

    task automatic wait_init(output int n, output bit req_seen);
        n = 0;
        req_seen = 1'b0;
        while (busy && n < 1000) begin
            n++;
            if (mem_req) req_seen = 1'b1;
            @(negedge gclk);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic frc, output logic [31:0] rd, output int stall);
        int n;
        n = 0;
        while (busy && n < 200) begin @(negedge gclk); n++; end
        if (busy) begin
            checks++; fails++;
            $display("FAIL access_ready: busy still %b after %0d cycles, required 0", busy, n);
        end
        p_addr = a; p_en = 1'b1; p_we = we; p_force = frc;
        @(negedge gclk);
        p_en = 1'b0; p_we = 1'b0; p_force = 1'b0; datao = wd;
        stall = 0;
        while (busy && stall < 200) begin @(negedge gclk); stall++; end
        if (busy) begin
            checks++; fails++;
            $display("FAIL access_done: busy still %b at addr %h, required 0", busy, a);
        end
        rd = datai;
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        grst = 1'b1;
        @(negedge gclk);
        grst = 1'b0;
        repeat (3) @(negedge gclk);
        checks++; if (busy !== 1'b1)     begin fails++; $display("FAIL reset_busy: got %b required 1", busy); end
        checks++; if (mem_req !== 1'b0)  begin fails++; $display("FAIL reset_req: got %b required 0", mem_req); end
        checks++; if (datai !== 32'h0)   begin fails++; $display("FAIL reset_datai: got %h required 0", datai); end
        checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
        grst = 1'b1;
        wait_init(n, seen);
        checks++; if (n !== 64)  begin fails++; $display("FAIL init_busy_cycles: got %0d required 64", n); end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL init_req: got %b required 0", seen); end
    endtask

    task automatic test_fill();
        logic [31:0] d;
        logic [31:0] exp_a [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        int st, base;
        mem_model[32'h100] = 32'h11; mem_model[32'h104] = 32'h22;
        mem_model[32'h108] = 32'h33; mem_model[32'h10C] = 32'h44;
        base = rd_log.size();
        access(32'h100, 1'b0, 32'h0, 1'b0, d, st);
        checks++; if (rd_log.size() !== base + 4) begin fails++; $display("FAIL fill_reads: got %0d required 4", rd_log.size() - base); end
        for (int i = 0; i < 4; i++) begin
            if (base + i < rd_log.size()) begin
                checks++;
                if (rd_log[base+i] !== exp_a[i]) begin fails++; $display("FAIL fill_addr%0d: got %h required %h", i, rd_log[base+i], exp_a[i]); end
            end
        end
        checks++; if (d !== 32'h11) begin fails++; $display("FAIL fill_data: got %h required 00000011", d); end
        base = rd_log.size();
        access(32'h108, 1'b0, 32'h0, 1'b0, d, st);
        checks++; if (d !== 32'h33) begin fails++; $display("FAIL hit_data: got %h required 00000033", d); end
        checks++; if (rd_log.size() !== base) begin fails++; $display("FAIL hit_noreq: got %0d reads required 0", rd_log.size() - base); end
        checks++; if (st !== 0) begin fails++; $display("FAIL hit_stall: got %0d required 0", st); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        int s1, s2;
        access(32'h104, 1'b0, 32'h0, 1'b0, d1, s1);
        access(32'h10C, 1'b0, 32'h0, 1'b0, d2, s2);
        checks++; if (d1 !== 32'h22) begin fails++; $display("FAIL b2b_data0: got %h required 00000022", d1); end
        checks++; if (d2 !== 32'h44) begin fails++; $display("FAIL b2b_data1: got %h required 00000044", d2); end
        checks++; if (s1 + s2 !== 0) begin fails++; $display("FAIL b2b_stall: got %0d required 0", s1 + s2); end
    endtask

    task automatic test_store();
        logic [31:0] d;
        int st, rb, wb;
        rb = rd_log.size(); wb = wr_log_addr.size();
        access(32'h104, 1'b1, 32'hDEADBEEF, 1'b0, d, st);
        checks++; if (wr_log_addr.size() !== wb + 1) begin fails++; $display("FAIL store_writes: got %0d required 1", wr_log_addr.size() - wb); end
        if (wr_log_addr.size() > wb) begin
            checks++; if (wr_log_addr[wb] !== 32'h104) begin fails++; $display("FAIL store_addr: got %h required 00000104", wr_log_addr[wb]); end
            checks++; if (wr_log_data[wb] !== 32'hDEADBEEF) begin fails++; $display("FAIL store_wdata: got %h required deadbeef", wr_log_data[wb]); end
        end
        access(32'h104, 1'b0, 32'h0, 1'b0, d, st);
        checks++; if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL store_hit_load: got %h required deadbeef", d); end
        checks++; if (rd_log.size() !== rb) begin fails++; $display("FAIL store_nofill: got %0d reads required 0", rd_log.size() - rb); end
        wb = wr_log_addr.size();
        access(32'h900, 1'b1, 32'hCAFEF00D, 1'b0, d, st);
        checks++; if (wr_log_addr.size() !== wb + 1 || rd_log.size() !== rb) begin
            fails++; $display("FAIL store_miss: got %0d writes %0d reads required 1 and 0", wr_log_addr.size() - wb, rd_log.size() - rb);
        end
        access(32'h900, 1'b0, 32'h0, 1'b0, d, st);
        checks++; if (rd_log.size() !== rb + 4) begin fails++; $display("FAIL noalloc_fill: got %0d reads required 4", rd_log.size() - rb); end
        checks++; if (d !== 32'hCAFEF00D) begin fails++; $display("FAIL noalloc_data: got %h required cafef00d", d); end
    endtask

    task automatic test_force();
        logic [31:0] d;
        int st, rb;
        access(32'h100, 1'b0, 32'h0, 1'b0, d, st);
        checks++; if (d !== 32'h11) begin fails++; $display("FAIL force_pre: got %h required 00000011", d); end
        mem_model[32'h100] = 32'h55;
        rb = rd_log.size();
        access(32'h100, 1'b0, 32'h0, 1'b1, d, st);
        checks++; if (rd_log.size() !== rb + 1) begin fails++; $display("FAIL force_reads: got %0d required 1", rd_log.size() - rb); end
        if (rd_log.size() > rb) begin
            checks++; if (rd_log[rb] !== 32'h100) begin fails++; $display("FAIL force_addr: got %h required 00000100", rd_log[rb]); end
        end
        checks++; if (d !== 32'h55) begin fails++; $display("FAIL force_data: got %h required 00000055", d); end
        rb = rd_log.size();
        access(32'h100, 1'b0, 32'h0, 1'b0, d, st);
        checks++; if (d !== 32'h11 || rd_log.size() !== rb) begin
            fails++; $display("FAIL force_untouched: got %h with %0d reads required 00000011 with 0", d, rd_log.size() - rb);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] d;
        int st, rb;
        mem_model[32'h500] = 32'h5005;
        rb = rd_log.size();
        access(32'h100, 1'b0, 32'h0, 1'b0, d, st);
        access(32'h500, 1'b0, 32'h0, 1'b0, d, st);
        checks++; if (rd_log.size() !== rb + 4) begin fails++; $display("FAIL conflict_fill: got %0d reads required 4", rd_log.size() - rb); end
        checks++; if (d !== 32'h5005) begin fails++; $display("FAIL conflict_data: got %h required 00005005", d); end
        rb = rd_log.size();
        access(32'h100, 1'b0, 32'h0, 1'b0, d, st);
        checks++; if (rd_log.size() !== rb + 4) begin fails++; $display("FAIL conflict_refill: got %0d reads required 4", rd_log.size() - rb); end
        checks++; if (d !== 32'h55) begin fails++; $display("FAIL conflict_redata: got %h required 00000055", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int n, rb, st;
        bit seen;
        n = 0;
        while (busy && n < 200) begin @(negedge gclk); n++; end
        rb = rd_log.size();
        p_addr = 32'h3000; p_en = 1'b1; p_we = 1'b0; p_force = 1'b0;
        @(negedge gclk);
        p_en = 1'b0;
        n = 0;
        while (rd_log.size() < rb + 2 && n < 200) begin @(negedge gclk); n++; end
        checks++; if (rd_log.size() !== rb + 2) begin fails++; $display("FAIL mid_acks: got %0d required 2", rd_log.size() - rb); end
        @(posedge gclk);
        #1 grst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mid_req_drop: got %b required 0", mem_req); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b required 1", busy); end
        repeat (3) @(negedge gclk);
        grst = 1'b1;
        wait_init(n, seen);
        checks++; if (n !== 64 || seen !== 1'b0) begin
            fails++; $display("FAIL mid_init: got %0d cycles req_seen %b required 64 and 0", n, seen);
        end
        rb = rd_log.size();
        access(32'h100, 1'b0, 32'h0, 1'b0, d, st);
        checks++; if (rd_log.size() !== rb + 4) begin fails++; $display("FAIL mid_refill: got %0d reads required 4", rd_log.size() - rb); end
        checks++; if (d !== 32'h55) begin fails++; $display("FAIL mid_data: got %h required 00000055", d); end
    endtask

    initial begin
        grst = 1'b1; p_addr = '0; p_en = 1'b0; p_we = 1'b0; p_force = 1'b0;
        datao = '0; mem_rdata = '0; mem_ack = 1'b0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_store();
        test_force();
        test_conflict();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
